// File: rtl/sincos_pwl_pipe.sv
// Pipelined sine/cosine: quadrant reduction, piecewise-linear C1*x+C0 from external
// synchronous ROMs, clamp/saturate, quadrant reconstruction. Single-enable valid/ready.
module sincos_pwl_pipe #(
  parameter int IN_W     = 16,
  parameter int SEG_BITS = 7,
  parameter int OUT_W    = 16,
  parameter int C1_W     = 12,
  parameter int C0_W     = 19,
  parameter int TAG_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_phase,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [SEG_BITS-1:0]     sin_addr,
  output logic [SEG_BITS-1:0]     cos_addr,
  input  logic [C1_W+C0_W-1:0]    sin_coef,
  input  logic [C1_W+C0_W-1:0]    cos_coef,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_cos,
  output logic signed [OUT_W-1:0] out_sin,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int XW = IN_W - 2;
  localparam int F  = XW - SEG_BITS;
  localparam int CW = C1_W + C0_W;
  localparam int PW = C1_W + F + 1;
  localparam int SW = C0_W + 2;
  localparam int SH = C0_W - OUT_W + 1;
  localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  // Offset plus scaled slope term; negative sums clamp to zero, overshoot saturates.
  function automatic logic signed [OUT_W-1:0] pwl_sat(input logic signed [PW-1:0] p,
                                                      input logic [C0_W-1:0] c0);
    logic signed [PW-1:0] t;
    logic signed [SW-1:0] s;
    logic [SW-1:0]        q;
    t = p >>> F;
    s = $signed({2'b00, c0}) + SW'(t);
    q = $unsigned(s) >> SH;
    if (s[SW-1])
      pwl_sat = '0;
    else if (q > SW'(Y_MAX))
      pwl_sat = Y_MAX;
    else
      pwl_sat = q[OUT_W-1:0];
  endfunction

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic [XW-1:0] xa, xb;
  assign xa = in_phase[XW-1:0];
  assign xb = {XW{1'b1}} - xa;

  // Stage A: range reduction and ROM addressing
  logic             vld_p0;
  logic [1:0]       quad_p0;
  logic [F-1:0]     fa_p0, fb_p0;
  logic [TAG_W-1:0] tag_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      quad_p0  <= '0;
      fa_p0    <= '0;
      fb_p0    <= '0;
      tag_p0   <= '0;
      sin_addr <= '0;
      cos_addr <= '0;
    end else if (en) begin
      vld_p0   <= in_valid;
      quad_p0  <= in_phase[IN_W-1:IN_W-2];
      fa_p0    <= xa[F-1:0];
      fb_p0    <= xb[F-1:0];
      tag_p0   <= in_tag;
      sin_addr <= xa[XW-1:F];
      cos_addr <= xb[XW-1:F];
    end
  end

  // Stage B: coefficient capture
  logic                   vld_p1;
  logic [1:0]             quad_p1;
  logic [F-1:0]           fa_p1, fb_p1;
  logic [TAG_W-1:0]       tag_p1;
  logic signed [C1_W-1:0] c1s_p1, c1c_p1;
  logic [C0_W-1:0]        c0s_p1, c0c_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      quad_p1 <= '0;
      fa_p1   <= '0;
      fb_p1   <= '0;
      tag_p1  <= '0;
      c1s_p1  <= '0;
      c1c_p1  <= '0;
      c0s_p1  <= '0;
      c0c_p1  <= '0;
    end else if (en) begin
      vld_p1  <= vld_p0;
      quad_p1 <= quad_p0;
      fa_p1   <= fa_p0;
      fb_p1   <= fb_p0;
      tag_p1  <= tag_p0;
      c1s_p1  <= $signed(sin_coef[CW-1:C0_W]);
      c1c_p1  <= $signed(cos_coef[CW-1:C0_W]);
      c0s_p1  <= sin_coef[C0_W-1:0];
      c0c_p1  <= cos_coef[C0_W-1:0];
    end
  end

  // Stage C: slope products, signed C1 by unsigned fraction
  logic signed [PW-1:0] pa_c, pb_c;
  assign pa_c = PW'(c1s_p1) * $signed(PW'({1'b0, fa_p1}));
  assign pb_c = PW'(c1c_p1) * $signed(PW'({1'b0, fb_p1}));

  logic                 vld_p2;
  logic [1:0]           quad_p2;
  logic [TAG_W-1:0]     tag_p2;
  logic signed [PW-1:0] pa_p2, pb_p2;
  logic [C0_W-1:0]      c0s_p2, c0c_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      quad_p2 <= '0;
      tag_p2  <= '0;
      pa_p2   <= '0;
      pb_p2   <= '0;
      c0s_p2  <= '0;
      c0c_p2  <= '0;
    end else if (en) begin
      vld_p2  <= vld_p1;
      quad_p2 <= quad_p1;
      tag_p2  <= tag_p1;
      pa_p2   <= pa_c;
      pb_p2   <= pb_c;
      c0s_p2  <= c0s_p1;
      c0c_p2  <= c0c_p1;
    end
  end

  // Stage D: offset add, clamp and saturate
  logic                    vld_p3;
  logic [1:0]              quad_p3;
  logic [TAG_W-1:0]        tag_p3;
  logic signed [OUT_W-1:0] ya_p3, yb_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p3  <= 1'b0;
      quad_p3 <= '0;
      tag_p3  <= '0;
      ya_p3   <= '0;
      yb_p3   <= '0;
    end else if (en) begin
      vld_p3  <= vld_p2;
      quad_p3 <= quad_p2;
      tag_p3  <= tag_p2;
      ya_p3   <= pwl_sat(pa_p2, c0s_p2);
      yb_p3   <= pwl_sat(pb_p2, c0c_p2);
    end
  end

  // Stage E: quadrant reconstruction; negation cannot overflow since y <= Y_MAX
  logic signed [OUT_W-1:0] cos_c, sin_c;

  always_comb begin
    cos_c = yb_p3;
    sin_c = ya_p3;
    case (quad_p3)
      2'd1: begin cos_c = -ya_p3; sin_c =  yb_p3; end
      2'd2: begin cos_c = -yb_p3; sin_c = -ya_p3; end
      2'd3: begin cos_c =  ya_p3; sin_c = -yb_p3; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cos   <= '0;
      out_sin   <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= vld_p3;
      out_cos   <= cos_c;
      out_sin   <= sin_c;
      out_tag   <= tag_p3;
    end
  end

endmodule
